// File: rtl/multiword_addsub_seq_pkg.sv
// Shared opcode values, FSM state encoding and the final-word flag payload
// used by the multi-word add/subtract block.
package multiword_addsub_seq_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Status reported alongside the MSW of a result
  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
  } flags_t;

endpackage : multiword_addsub_seq_pkg

// File: rtl/multiword_addsub_seq_unit_sum.sv
// Dual-path word adder: produces A+B and A+B+1 in parallel so the caller
// can carry-select between them once the incoming carry is known.
module unit_sum #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum0,
  output logic             cout0,
  output logic [WIDTH-1:0] sum1,
  output logic             cout1
);

  localparam int unsigned W1 = WIDTH + 1;

  logic [WIDTH:0] w_p0;
  logic [WIDTH:0] w_p1;

  assign w_p0  = W1'(a) + W1'(b);
  assign w_p1  = W1'(a) + W1'(b) + W1'(1);
  assign sum0  = w_p0[WIDTH-1:0];
  assign cout0 = w_p0[WIDTH];
  assign sum1  = w_p1[WIDTH-1:0];
  assign cout1 = w_p1[WIDTH];

endmodule : unit_sum

// File: rtl/multiword_addsub_seq.sv
// Streaming multi-word adder/subtractor, LSW first, one result word per cycle.
// Optional zero/overflow flags are built when ALU_SEQ_FLAGS_EN is defined.
module multiword_addsub_seq
  import multiword_addsub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf
);

  state_e           r_state;
  state_e           r_state_nxt;
  logic             r_carry;
  logic             r_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_last;
  flags_t           r_flags;

  logic             w_accept;
  logic             w_first;
  logic             w_op;
  logic             w_cin;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum0;
  logic [WIDTH-1:0] w_sum1;
  logic             w_cout0;
  logic             w_cout1;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_zero;
  logic             w_ovf;

  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  // A word arriving in IDLE starts a new operand even without in_first
  assign w_first  = in_first | (r_state == ST_IDLE);
  assign w_op     = w_first ? in_op : r_op;
  assign w_cin    = w_first ? in_op : r_carry;
  assign w_b_eff  = w_op ? ~in_b : in_b;

  unit_sum #(.WIDTH(WIDTH)) u_sum (
    .a     (in_a),
    .b     (w_b_eff),
    .sum0  (w_sum0),
    .cout0 (w_cout0),
    .sum1  (w_sum1),
    .cout1 (w_cout1)
  );

  assign w_sum  = w_cin ? w_sum1  : w_sum0;
  assign w_cout = w_cin ? w_cout1 : w_cout0;

`ifdef ALU_SEQ_FLAGS_EN
  logic r_zero_acc;
  logic w_zero_prev;

  assign w_zero_prev = w_first ? 1'b0 : r_zero_acc;
  assign w_zero      = ~(w_zero_prev | (|w_sum));
  assign w_ovf       = (in_a[WIDTH-1] == w_b_eff[WIDTH-1]) &
                       (w_sum[WIDTH-1] != in_a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero_acc <= 1'b0;
    end else if (w_accept) begin
      r_zero_acc <= w_zero_prev | (|w_sum);
    end
  end
`else
  assign w_zero = 1'b0;
  assign w_ovf  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    if (w_accept) begin
      r_state_nxt = in_last ? ST_IDLE : ST_BUSY;
    end
  end

  // Output register and running carry; everything holds while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carry     <= 1'b0;
      r_op        <= ALU_OP_ADD;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_last      <= 1'b0;
      r_flags     <= '0;
    end else if (w_accept) begin
      r_carry     <= w_cout;
      r_op        <= w_op;
      r_out_valid <= 1'b1;
      r_sum       <= w_sum;
      r_last      <= in_last;
      if (in_last) begin
        r_flags.carry <= w_cout;
        r_flags.zero  <= w_zero;
        r_flags.ovf   <= w_ovf;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_last  = r_last;
  assign out_carry = r_flags.carry;
  assign out_zero  = r_flags.zero;
  assign out_ovf   = r_flags.ovf;

endmodule : multiword_addsub_seq
